ysyx_22050058_ctrl: RTL and testbench
=====================================

Name: ysyx_22050058_ctrl

Overview:
Central pipeline controller for the 5-stage core. It turns per-stage stall requests into the shared 6-bit stall vector, and turns EX branch redirects and MEM traps into the flush vector plus a PC redirect to fetch. It holds a redirect until an in-flight instruction fetch completes, latches the halt (ebreak) condition, and counts stall cycles. It sits between the pipeline stages and the fetch unit, driving the stall and flush buses consumed by every pipeline register and by the instruction ROM.

Parameters:
ADDR_W, 64, PC / redirect target width
CNT_W, 32, stall-cycle counter width

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
stallreq_if_i  in  1  fetch in flight / ROM not ready
stallreq_id_i  in  1  load-use hazard in ID
stallreq_ex_i  in  1  multi-cycle EX op busy
stallreq_mem_i  in  1  data-memory wait
redirect_ex_i  in  1  EX branch/jump redirect request (level, held by EX while stalled)
redirect_ex_pc_i  in  ADDR_W  EX redirect target
trap_mem_i  in  1  MEM exception/mret redirect request
trap_mem_pc_i  in  ADDR_W  trap target
halt_i  in  1  ebreak retired in WB
stall_o  out  6  bit0=PC, 1=IF, 2=ID, 3=EX, 4=MEM, 5=WB; 1 = hold stage
flush_o  out  6  same bit mapping; 1 = bubble the stage register
redirect_o  out  1  fetch loads redirect_pc_o this cycle
redirect_pc_o  out  ADDR_W  new PC
halted_o  out  1  core halted
stall_cycles_o  out  CNT_W  count of cycles with stall_o[0]=1

Behaviour:
- Reset: while rst=1, all outputs are 0. On the following edge: state=RUN, pending cleared, counter=0.
- States: RUN, PEND (redirect waiting for fetch), HALT. All outputs are combinational from state, pending registers and inputs, so every effect is same-cycle.
- Stall priority in RUN/PEND: mem → 6'b011111; else ex → 6'b001111; else id → 6'b000111; else if → 6'b000011; else 0.
- Event priority each cycle: halt_i > trap_mem_i > redirect_ex_i.
- A redirect_ex_i is accepted only when stallreq_mem_i=0. While MEM is stalled, EX is frozen and EX keeps the request asserted.
- A trap is always accepted. The accepting cycle has stall_o=0 and flush_o=6'b011110.
- An accepted redirect has flush_o=6'b000110 and stall_o as per the priority above, with bits 1 and 2 forced to 0.
- If an event is accepted with stallreq_if_i=0: redirect_o=1 and redirect_pc_o=target in that cycle; state stays RUN.
- If an event is accepted with stallreq_if_i=1: latch target into pend_pc, go to PEND, redirect_o=0.
- In PEND: flush_o[1]=1 every cycle so the stale fetch is dropped. On the first cycle with stallreq_if_i=0: redirect_o=1, redirect_pc_o=pend_pc, then go to RUN.
- In PEND, a newly accepted trap/redirect overwrites pend_pc. A trap also applies its flush.
- halt_i from any state: go to HALT at the edge, dropping any pending redirect.
- HALT: stall_o=6'b111111, flush_o=0, redirect_o=0, halted_o=1. Only rst exits HALT.
- In the cycle halt_i is seen, stall_o=6'b111111 and no trap/redirect is taken.
- stall_cycles_o increments at the edge when stall_o[0]=1 and state≠HALT. It saturates at all-ones, no wrap.
- redirect_pc_o is 0 whenever redirect_o=0.

Test Plan:
- Stall priority: stallreq_id=1 → stall_o=000111. Add stallreq_mem=1 in the same cycle → 011111. Release both → 0. Counter advances by exactly the number of stalled cycles.
- Redirect with fetch idle: redirect_ex=1, pc=0x8000_0040, stallreq_if=0 → same cycle redirect_o=1, pc=0x8000_0040, flush_o=000110. Next cycle with no inputs → all 0.
- Redirect during fetch: stallreq_if=1 for 3 cycles, redirect at cycle 0 with pc=0x8000_0100 → flush_o[1]=1 in cycles 1–2, redirect_o=0 until stallreq_if falls, then a single-cycle redirect_o with 0x8000_0100.
- Overwrite and priority: trap (pc=0x8000_0200) and redirect (0x8000_0300) in the same cycle → trap wins, flush_o=011110. A trap arriving in PEND replaces pend_pc, and the final redirect carries the trap pc.
- Deferred redirect: redirect_ex=1 with stallreq_mem=1 → no flush, no redirect, stall_o=011111. Accepted in the cycle stallreq_mem falls.
- Halt: halt_i pulse in PEND → halted_o=1, stall_o=111111 forever, pending redirect never issued, counter frozen. Assert rst mid-halt → all outputs 0, then normal RUN.

Source files
------------

// File: rtl/ysyx_22050058_ctrl.sv
// Central pipeline controller: stall/flush vectors, fetch redirect, halt latch
// and a saturating stall-cycle counter for the 5-stage core.
module ysyx_22050058_ctrl #(
  parameter int ADDR_W = 64,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stallreq_if_i,
  input  logic              stallreq_id_i,
  input  logic              stallreq_ex_i,
  input  logic              stallreq_mem_i,
  input  logic              redirect_ex_i,
  input  logic [ADDR_W-1:0] redirect_ex_pc_i,
  input  logic              trap_mem_i,
  input  logic [ADDR_W-1:0] trap_mem_pc_i,
  input  logic              halt_i,
  output logic [5:0]        stall_o,
  output logic [5:0]        flush_o,
  output logic              redirect_o,
  output logic [ADDR_W-1:0] redirect_pc_o,
  output logic              halted_o,
  output logic [CNT_W-1:0]  stall_cycles_o
);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_PEND = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] pend_pc;
  logic [ADDR_W-1:0] pend_pc_nxt;
  logic [CNT_W-1:0]  cnt;

  logic              take_trap;
  logic              take_br;
  logic              take_evt;
  logic [ADDR_W-1:0] evt_pc;
  logic [5:0]        stall_base;

  // Deepest requesting stage freezes itself and everything upstream of it.
  function automatic logic [5:0] prio_stall(input logic mem, input logic ex,
                                            input logic id, input logic ifs);
    if (mem)      return 6'b011111;
    else if (ex)  return 6'b001111;
    else if (id)  return 6'b000111;
    else if (ifs) return 6'b000011;
    else          return 6'b000000;
  endfunction

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) return v;
    else    return v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  // Event arbitration: halt beats trap beats branch; a branch waits while MEM holds EX.
  always_comb begin
    take_trap  = trap_mem_i & ~halt_i;
    take_br    = redirect_ex_i & ~stallreq_mem_i & ~trap_mem_i & ~halt_i;
    take_evt   = take_trap | take_br;
    evt_pc     = trap_mem_i ? trap_mem_pc_i : redirect_ex_pc_i;
    stall_base = prio_stall(stallreq_mem_i, stallreq_ex_i, stallreq_id_i, stallreq_if_i);
  end

  // State, pending target and stall counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (stall_o[0] && (state != ST_HALT)) cnt <= sat_inc(cnt);
    end
    pend_pc <= pend_pc_nxt;
  end

  // Next state: park a redirect while a fetch is in flight, release it once fetch idles.
  always_comb begin
    state_nxt   = state;
    pend_pc_nxt = pend_pc;
    case (state)
      ST_HALT: state_nxt = ST_HALT;
      default: begin
        if (halt_i) begin
          state_nxt = ST_HALT;
        end else if (take_evt) begin
          if (stallreq_if_i) begin
            state_nxt   = ST_PEND;
            pend_pc_nxt = evt_pc;
          end else begin
            state_nxt = ST_RUN;
          end
        end else if ((state == ST_PEND) && !stallreq_if_i) begin
          state_nxt = ST_RUN;
        end
      end
    endcase
  end

  // Outputs: all same-cycle from state, pending target and current requests.
  always_comb begin
    stall_o        = 6'b000000;
    flush_o        = 6'b000000;
    redirect_o     = 1'b0;
    redirect_pc_o  = '0;
    halted_o       = 1'b0;
    stall_cycles_o = '0;
    if (!rst) begin
      stall_cycles_o = cnt;
      if (state == ST_HALT) begin
        stall_o  = 6'b111111;
        halted_o = 1'b1;
      end else if (halt_i) begin
        stall_o = 6'b111111;
      end else begin
        stall_o = stall_base;
        if (take_trap) begin
          stall_o = 6'b000000;
          flush_o = 6'b011110;
        end else if (take_br) begin
          // IF and ID are bubbled, so they must be allowed to load.
          stall_o = stall_base & 6'b111001;
          flush_o = 6'b000110;
        end
        // Drop whatever the in-flight fetch returns while a redirect waits.
        if (state == ST_PEND) flush_o[1] = 1'b1;
        if (take_evt) begin
          if (!stallreq_if_i) begin
            redirect_o    = 1'b1;
            redirect_pc_o = evt_pc;
          end
        end else if ((state == ST_PEND) && !stallreq_if_i) begin
          redirect_o    = 1'b1;
          redirect_pc_o = pend_pc;
        end
      end
    end
  end

endmodule

// File: tb/tb_ysyx_22050058_ctrl.sv
// Bench for ysyx_22050058_ctrl: directed scenarios plus randomized run against
// a behavioural model of the controller.
module tb_ysyx_22050058_ctrl;

  localparam int ADDR_W = 64;
  localparam int CNT_W  = 4;
  localparam logic [CNT_W-1:0] CMAX = '1;

  logic              clk = 1'b0;
  logic              rst;
  logic              stallreq_if_i, stallreq_id_i, stallreq_ex_i, stallreq_mem_i;
  logic              redirect_ex_i, trap_mem_i, halt_i;
  logic [ADDR_W-1:0] redirect_ex_pc_i, trap_mem_pc_i;
  logic [5:0]        stall_o, flush_o;
  logic              redirect_o, halted_o;
  logic [ADDR_W-1:0] redirect_pc_o;
  logic [CNT_W-1:0]  stall_cycles_o;
  logic [13:0]       obs;

  int n_tests = 0;
  int n_fail  = 0;

  // model state
  logic              m_halted, m_pending;
  logic [ADDR_W-1:0] m_pend_pc;
  logic [CNT_W-1:0]  m_cnt;
  // model expectations for the current cycle
  logic [13:0]       e_obs;
  logic [ADDR_W-1:0] e_pc;
  logic [CNT_W-1:0]  e_cnt;
  logic              e_evt;
  logic [ADDR_W-1:0] e_tgt;

  ysyx_22050058_ctrl #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .stallreq_if_i(stallreq_if_i), .stallreq_id_i(stallreq_id_i),
    .stallreq_ex_i(stallreq_ex_i), .stallreq_mem_i(stallreq_mem_i),
    .redirect_ex_i(redirect_ex_i), .redirect_ex_pc_i(redirect_ex_pc_i),
    .trap_mem_i(trap_mem_i), .trap_mem_pc_i(trap_mem_pc_i),
    .halt_i(halt_i),
    .stall_o(stall_o), .flush_o(flush_o), .redirect_o(redirect_o),
    .redirect_pc_o(redirect_pc_o), .halted_o(halted_o),
    .stall_cycles_o(stall_cycles_o)
  );

  assign obs = {stall_o, flush_o, redirect_o, halted_o};

  always #5 clk = ~clk;

  // Reference: what the controller should show this cycle, from the rules.
  task automatic model_eval();
    logic [5:0] s, f;
    logic r, h, trap, br;
    logic [ADDR_W-1:0] p;
    s = 6'd0; f = 6'd0; r = 1'b0; h = 1'b0; p = '0; trap = 1'b0; br = 1'b0;
    if (rst) begin
    end else if (m_halted) begin
      s = 6'b111111; h = 1'b1;
    end else if (halt_i) begin
      s = 6'b111111;
    end else begin
      if (stallreq_mem_i)     s = 6'b011111;
      else if (stallreq_ex_i) s = 6'b001111;
      else if (stallreq_id_i) s = 6'b000111;
      else if (stallreq_if_i) s = 6'b000011;
      trap = trap_mem_i;
      br   = !trap && redirect_ex_i && !stallreq_mem_i;
      if (trap) begin s = 6'd0; f = 6'b011110; end
      else if (br) begin s[2:1] = 2'b00; f = 6'b000110; end
      if (m_pending) f[1] = 1'b1;
      if (trap || br) begin
        if (!stallreq_if_i) begin r = 1'b1; p = trap ? trap_mem_pc_i : redirect_ex_pc_i; end
      end else if (m_pending && !stallreq_if_i) begin
        r = 1'b1; p = m_pend_pc;
      end
    end
    e_obs = {s, f, r, h};
    e_pc  = p;
    e_cnt = rst ? '0 : m_cnt;
    e_evt = trap || br;
    e_tgt = trap_mem_i ? trap_mem_pc_i : redirect_ex_pc_i;
  endtask

  task automatic model_step();
    if (rst) begin
      m_halted = 1'b0; m_pending = 1'b0; m_cnt = '0;
    end else if (!m_halted) begin
      if (e_obs[8] && m_cnt != CMAX) m_cnt = m_cnt + 1'b1;
      if (halt_i) begin
        m_halted = 1'b1; m_pending = 1'b0;
      end else if (e_evt) begin
        if (stallreq_if_i) begin m_pending = 1'b1; m_pend_pc = e_tgt; end
        else m_pending = 1'b0;
      end else if (m_pending && !stallreq_if_i) begin
        m_pending = 1'b0;
      end
    end
  endtask

  task automatic tick();
    model_eval();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic clr();
    rst = 1'b0; stallreq_if_i = 1'b0; stallreq_id_i = 1'b0; stallreq_ex_i = 1'b0;
    stallreq_mem_i = 1'b0; redirect_ex_i = 1'b0; trap_mem_i = 1'b0; halt_i = 1'b0;
    redirect_ex_pc_i = '0; trap_mem_pc_i = '0;
  endtask

  task automatic do_reset();
    clr(); rst = 1'b1; tick(); tick(); clr(); #1;
  endtask

  task automatic test_reset();
    logic [13:0] want;
    clr(); rst = 1'b1;
    stallreq_mem_i = 1'b1; trap_mem_i = 1'b1; halt_i = 1'b1; trap_mem_pc_i = 64'h1234;
    #1;
    want = 14'd0;
    n_tests++;
    if (obs !== want || redirect_pc_o !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got %h pc %h want %h pc 0", obs, redirect_pc_o, want);
    end
    tick(); tick();
    clr(); #1;
    n_tests++;
    if (obs !== 14'd0 || stall_cycles_o !== '0) begin
      n_fail++; $display("FAIL reset_release: got %h cnt %0d want 0 cnt 0", obs, stall_cycles_o);
    end
  endtask

  task automatic test_stall_priority();
    logic [13:0] want;
    do_reset();
    stallreq_id_i = 1'b1; #1;
    want = {6'b000111, 6'b000000, 2'b00};
    n_tests++;
    if (obs !== want) begin n_fail++; $display("FAIL stall_id: got %h want %h", obs, want); end
    tick();
    stallreq_mem_i = 1'b1; #1;
    want = {6'b011111, 6'b000000, 2'b00};
    n_tests++;
    if (obs !== want) begin n_fail++; $display("FAIL stall_mem: got %h want %h", obs, want); end
    tick();
    clr(); #1;
    n_tests++;
    if (obs !== 14'd0) begin n_fail++; $display("FAIL stall_release: got %h want 0", obs); end
    n_tests++;
    if (stall_cycles_o !== 4'd2) begin
      n_fail++; $display("FAIL stall_count: got %0d want 2", stall_cycles_o);
    end
    tick();
  endtask

  task automatic test_redirect_idle();
    logic [13:0] want;
    do_reset();
    redirect_ex_i = 1'b1; redirect_ex_pc_i = 64'h8000_0040; #1;
    want = {6'b000000, 6'b000110, 2'b10};
    n_tests++;
    if (obs !== want || redirect_pc_o !== 64'h8000_0040) begin
      n_fail++; $display("FAIL redir_idle: got %h pc %h want %h pc 80000040", obs, redirect_pc_o, want);
    end
    tick();
    clr(); #1;
    n_tests++;
    if (obs !== 14'd0 || redirect_pc_o !== '0) begin
      n_fail++; $display("FAIL redir_idle_after: got %h pc %h want 0", obs, redirect_pc_o);
    end
    tick();
  endtask

  task automatic test_redirect_fetch();
    logic [13:0] want;
    do_reset();
    stallreq_if_i = 1'b1; redirect_ex_i = 1'b1; redirect_ex_pc_i = 64'h8000_0100; #1;
    want = {6'b000001, 6'b000110, 2'b00};
    n_tests++;
    if (obs !== want || redirect_pc_o !== '0) begin
      n_fail++; $display("FAIL redir_fetch_c0: got %h pc %h want %h", obs, redirect_pc_o, want);
    end
    tick();
    redirect_ex_i = 1'b0; redirect_ex_pc_i = '0;
    for (int c = 1; c <= 2; c++) begin
      #1;
      want = {6'b000011, 6'b000010, 2'b00};
      n_tests++;
      if (obs !== want || redirect_pc_o !== '0) begin
        n_fail++; $display("FAIL redir_fetch_pend%0d: got %h pc %h want %h", c, obs, redirect_pc_o, want);
      end
      tick();
    end
    stallreq_if_i = 1'b0; #1;
    want = {6'b000000, 6'b000010, 2'b10};
    n_tests++;
    if (obs !== want || redirect_pc_o !== 64'h8000_0100) begin
      n_fail++; $display("FAIL redir_fetch_issue: got %h pc %h want %h pc 80000100", obs, redirect_pc_o, want);
    end
    tick(); #1;
    n_tests++;
    if (obs !== 14'd0) begin n_fail++; $display("FAIL redir_fetch_single: got %h want 0", obs); end
    tick();
  endtask

  task automatic test_trap_priority();
    logic [13:0] want;
    do_reset();
    trap_mem_i = 1'b1; trap_mem_pc_i = 64'h8000_0200;
    redirect_ex_i = 1'b1; redirect_ex_pc_i = 64'h8000_0300; #1;
    want = {6'b000000, 6'b011110, 2'b10};
    n_tests++;
    if (obs !== want || redirect_pc_o !== 64'h8000_0200) begin
      n_fail++; $display("FAIL trap_wins: got %h pc %h want %h pc 80000200", obs, redirect_pc_o, want);
    end
    tick();
    clr(); stallreq_if_i = 1'b1; redirect_ex_i = 1'b1; redirect_ex_pc_i = 64'h8000_0300;
    tick();
    redirect_ex_i = 1'b0; trap_mem_i = 1'b1; trap_mem_pc_i = 64'h8000_0200; #1;
    want = {6'b000000, 6'b011110, 2'b00};
    n_tests++;
    if (obs !== want) begin n_fail++; $display("FAIL trap_in_pend: got %h want %h", obs, want); end
    tick();
    clr(); #1;
    want = {6'b000000, 6'b000010, 2'b10};
    n_tests++;
    if (obs !== want || redirect_pc_o !== 64'h8000_0200) begin
      n_fail++; $display("FAIL trap_overwrite: got %h pc %h want %h pc 80000200", obs, redirect_pc_o, want);
    end
    tick();
  endtask

  task automatic test_deferred();
    logic [13:0] want;
    do_reset();
    stallreq_mem_i = 1'b1; redirect_ex_i = 1'b1; redirect_ex_pc_i = 64'h8000_0400; #1;
    want = {6'b011111, 6'b000000, 2'b00};
    n_tests++;
    if (obs !== want) begin n_fail++; $display("FAIL deferred_hold: got %h want %h", obs, want); end
    tick();
    stallreq_mem_i = 1'b0; #1;
    want = {6'b000000, 6'b000110, 2'b10};
    n_tests++;
    if (obs !== want || redirect_pc_o !== 64'h8000_0400) begin
      n_fail++; $display("FAIL deferred_accept: got %h pc %h want %h pc 80000400", obs, redirect_pc_o, want);
    end
    tick();
  endtask

  task automatic test_halt();
    logic [13:0] want;
    logic [CNT_W-1:0] frozen;
    do_reset();
    stallreq_if_i = 1'b1; redirect_ex_i = 1'b1; redirect_ex_pc_i = 64'h8000_0500;
    tick();
    redirect_ex_i = 1'b0; halt_i = 1'b1; #1;
    want = {6'b111111, 6'b000000, 2'b00};
    n_tests++;
    if (obs !== want) begin n_fail++; $display("FAIL halt_cycle: got %h want %h", obs, want); end
    tick();
    clr(); #1;
    frozen = stall_cycles_o;
    n_tests++;
    if (frozen !== m_cnt) begin n_fail++; $display("FAIL halt_count: got %0d want %0d", frozen, m_cnt); end
    for (int c = 0; c < 4; c++) begin
      stallreq_id_i = c[0]; trap_mem_i = c[1]; #1;
      want = {6'b111111, 6'b000000, 2'b01};
      n_tests++;
      if (obs !== want || redirect_pc_o !== '0 || stall_cycles_o !== frozen) begin
        n_fail++; $display("FAIL halt_hold%0d: got %h cnt %0d want %h cnt %0d", c, obs, stall_cycles_o, want, frozen);
      end
      tick();
    end
    clr(); rst = 1'b1; #1;
    n_tests++;
    if (obs !== 14'd0 || stall_cycles_o !== '0) begin
      n_fail++; $display("FAIL halt_rst: got %h cnt %0d want 0", obs, stall_cycles_o);
    end
    tick();
    clr(); redirect_ex_i = 1'b1; redirect_ex_pc_i = 64'h8000_0600; #1;
    want = {6'b000000, 6'b000110, 2'b10};
    n_tests++;
    if (obs !== want || redirect_pc_o !== 64'h8000_0600 || stall_cycles_o !== '0) begin
      n_fail++; $display("FAIL halt_recover: got %h pc %h want %h pc 80000600", obs, redirect_pc_o, want);
    end
    tick();
  endtask

  task automatic test_saturation();
    do_reset();
    stallreq_id_i = 1'b1;
    for (int c = 0; c < 20; c++) tick();
    clr(); #1;
    n_tests++;
    if (stall_cycles_o !== 4'hF) begin
      n_fail++; $display("FAIL cnt_saturate: got %0d want 15", stall_cycles_o);
    end
    tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      rst              = ($urandom_range(0, 99) == 0);
      stallreq_if_i    = ($urandom_range(0, 2) == 0);
      stallreq_id_i    = ($urandom_range(0, 7) == 0);
      stallreq_ex_i    = ($urandom_range(0, 7) == 0);
      stallreq_mem_i   = ($urandom_range(0, 5) == 0);
      redirect_ex_i    = ($urandom_range(0, 3) == 0);
      trap_mem_i       = ($urandom_range(0, 11) == 0);
      halt_i           = ($urandom_range(0, 149) == 0);
      redirect_ex_pc_i = {$urandom, $urandom};
      trap_mem_pc_i    = {$urandom, $urandom};
      #1;
      model_eval();
      n_tests++;
      if (obs !== e_obs || redirect_pc_o !== e_pc || stall_cycles_o !== e_cnt) begin
        n_fail++;
        $display("FAIL random_c%0d: got %h pc %h cnt %0d want %h pc %h cnt %0d",
                 c, obs, redirect_pc_o, stall_cycles_o, e_obs, e_pc, e_cnt);
      end
      tick();
    end
  endtask

  initial begin
    m_halted = 1'b0; m_pending = 1'b0; m_pend_pc = '0; m_cnt = '0;
    clr();
    @(negedge clk);
    test_reset();
    test_stall_priority();
    test_redirect_idle();
    test_redirect_fetch();
    test_trap_priority();
    test_deferred();
    test_halt();
    test_saturation();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
